// File: rtl/load_store_unit.sv
// Load/store unit: splits byte/half/word accesses into word-aligned memory cycles and returns one registered response.
// Define LSU_MISALIGNED_EN to allow any byte offset (split accesses); otherwise misaligned half/word requests are errors.
module load_store_unit #(
    parameter int WORD_WIDTH = 32,
    parameter int WE_WIDTH   = WORD_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [WORD_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic [WE_WIDTH-1:0]   mem_we,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, LO, HI, CAP} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    unsigned_q, unsigned_d;
    logic [WORD_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]   buf_q, buf_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [WORD_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                    reqErr;
    logic [1:0]              offset;
    logic [WE_WIDTH-1:0]     laneMask;
    logic [2*WE_WIDTH-1:0]   shMask;
    logic [2*WORD_WIDTH-1:0] shData;
    logic                    split;
    logic [WORD_WIDTH-1:0]   loAddr;
    logic [WORD_WIDTH-1:0]   hiAddr;
    logic [2*WORD_WIDTH-1:0] pair;
    logic [WORD_WIDTH-1:0]   assembled;
    logic [WORD_WIDTH-1:0]   loadResult;

    always_comb begin
        reqErr = (req_size == 2'b11);
`ifndef LSU_MISALIGNED_EN
        if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
            reqErr = 1'b1;
        end
`endif
    end

    // Lane mask and data are shifted into a two-word window; anything in the upper word needs a second access.
    always_comb begin
        offset = addr_q[1:0];
        case (size_q)
            2'b00:   laneMask = 4'b0001;
            2'b01:   laneMask = 4'b0011;
            default: laneMask = 4'b1111;
        endcase
        shMask = {{WE_WIDTH{1'b0}}, laneMask} << offset;
        shData = {{WORD_WIDTH{1'b0}}, wdata_q} << {offset, 3'b000};
        split  = |shMask[2*WE_WIDTH-1:WE_WIDTH];
        loAddr = {addr_q[WORD_WIDTH-1:2], 2'b00};
        hiAddr = loAddr + 32'd4;
    end

    always_comb begin
        pair      = split ? {mem_rdata, buf_q} : {{WORD_WIDTH{1'b0}}, mem_rdata};
        assembled = 32'(pair >> {offset, 3'b000});
        case (size_q)
            2'b00:   loadResult = unsigned_q ? {24'b0, assembled[7:0]}
                                             : {{24{assembled[7]}}, assembled[7:0]};
            2'b01:   loadResult = unsigned_q ? {16'b0, assembled[15:0]}
                                             : {{16{assembled[15]}}, assembled[15:0]};
            default: loadResult = assembled;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (reqErr) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = LO;
                        we_d       = req_we;
                        size_d     = req_size;
                        unsigned_d = req_unsigned;
                        addr_d     = req_addr;
                        wdata_d    = req_wdata;
                    end
                end
            end
            LO: begin
                mem_addr = loAddr;
                if (we_q) begin
                    mem_we    = shMask[WE_WIDTH-1:0];
                    mem_wdata = shData[WORD_WIDTH-1:0];
                end
                if (split) begin
                    state_d = HI;
                end else if (we_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAP;
                end
            end
            HI: begin
                mem_addr = hiAddr;
                if (we_q) begin
                    mem_we      = shMask[2*WE_WIDTH-1:WE_WIDTH];
                    mem_wdata   = shData[2*WORD_WIDTH-1:WORD_WIDTH];
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    buf_d   = mem_rdata;
                    state_d = CAP;
                end
            end
            CAP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = loadResult;
            end
            default: state_d = IDLE;
        endcase
        // A reset arriving mid-operation must not let the pending write commit.
        if (rst) begin
            mem_we = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read word memory on port 2.
// Covers both builds through LSU_MISALIGNED_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:1023] = '{default: '0};

    logic [3:0]  weLog    [1:8];
    logic [31:0] addrLog  [1:8];
    logic [31:0] wdataLog [1:8];
    int          rspLat;
    logic [31:0] rspData;
    logic        rspErrSeen;

    int compareCount = 0;
    int failCount    = 0;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte-enabled write and registered read, both on the rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        mem_rdata <= mem[mem_addr[11:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge with the unit idle; returns at the falling edge of the response cycle.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        rspLat       = -1;
        rspData      = '0;
        rspErrSeen   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            weLog[i]    = '0;
            addrLog[i]  = '0;
            wdataLog[i] = '0;
        end
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            weLog[c]    = mem_we;
            addrLog[c]  = mem_addr;
            wdataLog[c] = mem_wdata;
            if (rsp_valid) begin
                rspLat     = c;
                rspData    = rsp_rdata;
                rspErrSeen = rsp_err;
                break;
            end
        end
    endtask

    task automatic checkRsp(input string tag, input int lat, input logic [31:0] data, input logic err);
        checkOutput({tag, " latency"}, 32'(rspLat), 32'(lat));
        checkOutput({tag, " rdata"}, rspData, data);
        checkOutput({tag, " err"}, 32'(rspErrSeen), 32'(err));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset mem_we", 32'(mem_we), 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        checkRsp("sw 0x100", 2, 32'h0, 1'b0);
        checkOutput("sw 0x100 we", 32'(weLog[1]), 32'hF);
        checkOutput("sw 0x100 addr", addrLog[1], 32'h100);
        checkOutput("sw 0x100 wdata", wdataLog[1], 32'hDEADBEEF);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checkRsp("lw 0x100", 3, 32'hDEADBEEF, 1'b0);
        checkOutput("lw 0x100 addr", addrLog[1], 32'h100);
        checkOutput("lw 0x100 we", 32'(weLog[1]), 32'h0);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080);
        checkRsp("sb 0x103", 2, 32'h0, 1'b0);
        checkOutput("sb 0x103 we", 32'(weLog[1]), 32'h8);
        checkOutput("sb 0x103 wdata", wdataLog[1], 32'h80000000);
        checkOutput("sb 0x103 addr", addrLog[1], 32'h100);

        applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        checkRsp("lb 0x103", 3, 32'hFFFFFF80, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        checkRsp("lbu 0x103", 3, 32'h00000080, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        checkRsp("lh 0x102", 3, 32'hFFFF80AD, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
        checkRsp("lhu 0x100", 3, 32'h0000BEEF, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
        checkRsp("lb 0x101", 3, 32'hFFFFFFBE, 1'b0);

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234);
        checkRsp("sh 0x202", 2, 32'h0, 1'b0);
        checkOutput("sh 0x202 we", 32'(weLog[1]), 32'hC);
        checkOutput("sh 0x202 wdata", wdataLog[1], 32'h12340000);
        checkOutput("sh 0x202 addr", addrLog[1], 32'h200);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
        checkRsp("lh 0x202", 3, 32'h00001234, 1'b0);

        applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        checkRsp("load size11", 1, 32'h0, 1'b1);
        checkOutput("load size11 we", 32'(weLog[1]), 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF);
        checkRsp("store size11", 1, 32'h0, 1'b1);
        checkOutput("store size11 we", 32'(weLog[1]), 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checkRsp("lw after size11", 3, 32'h80ADBEEF, 1'b0);

        // Reset while a load sits in CAP: its response must never appear.
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst in CAP rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst in CAP req_ready", 32'(req_ready), 32'd1);

`ifndef LSU_MISALIGNED_EN
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        checkRsp("lw 0x102 misaligned", 1, 32'h0, 1'b1);
        checkOutput("lw 0x102 addr", addrLog[1], 32'h0);
        checkOutput("lw 0x102 we", 32'(weLog[1]), 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000FFFF);
        checkRsp("sh 0x101 misaligned", 1, 32'h0, 1'b1);
        checkOutput("sh 0x101 we", 32'(weLog[1]), 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checkRsp("lw after rejected sh", 3, 32'h80ADBEEF, 1'b0);
`else
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344);
        checkRsp("sw 0x102 split", 3, 32'h0, 1'b0);
        checkOutput("sw 0x102 LO addr", addrLog[1], 32'h100);
        checkOutput("sw 0x102 LO we", 32'(weLog[1]), 32'hC);
        checkOutput("sw 0x102 LO wdata", wdataLog[1], 32'h33440000);
        checkOutput("sw 0x102 HI addr", addrLog[2], 32'h104);
        checkOutput("sw 0x102 HI we", 32'(weLog[2]), 32'h3);
        checkOutput("sw 0x102 HI wdata", wdataLog[2], 32'h00001122);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        checkRsp("lw 0x102 split", 4, 32'h11223344, 1'b0);
        checkOutput("lw 0x102 LO addr", addrLog[1], 32'h100);
        checkOutput("lw 0x102 HI addr", addrLog[2], 32'h104);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0000009C);
        checkRsp("sb 0xFFFFFFFF", 2, 32'h0, 1'b0);
        checkOutput("sb 0xFFFFFFFF addr", addrLog[1], 32'hFFFFFFFC);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h0, 32'h000000C5);
        checkRsp("sb 0x0", 2, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
        checkRsp("lh wrap", 4, 32'hFFFFC59C, 1'b0);
        checkOutput("lh wrap LO addr", addrLog[1], 32'hFFFFFFFC);
        checkOutput("lh wrap HI addr", addrLog[2], 32'h00000000);

        // Reset during the HI cycle of a split store: only the LO bytes land.
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h301;
        req_wdata = 32'hA1B2C3D4; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst-HI LO we", 32'(mem_we), 32'hE);
        checkOutput("rst-HI LO addr", mem_addr, 32'h300);
        checkOutput("rst-HI LO wdata", mem_wdata, 32'hB2C3D400);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst-HI HI we", 32'(mem_we), 32'h0);
        checkOutput("rst-HI HI rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst-HI after rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst-HI after req_ready", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        checkRsp("lw 0x300 after rst", 3, 32'hB2C3D400, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
        checkRsp("lw 0x304 after rst", 3, 32'h0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
